// File: rtl/bilstm_direction_scheduler.sv
// Sequences the shared LSTM cell through the forward and backward passes of a BiLSTM,
// issuing one cell run at a time and writing each completed hidden state back by time index.
//   state     | meaning
//   IDLE      | waiting for start
//   ISSUE     | pulse cell_start for the current run
//   WAIT_DONE | waiting for cell_done, watchdog running
//   ADVANCE   | write h, step to the next run
//   FINISH    | pulse done, return to IDLE
module bilstm_direction_scheduler #(
  parameter int SEQ_LEN    = 10,
  parameter int IDX_W      = 4,
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 12,
  parameter int INTERLEAVE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cell_done,
  output logic             cell_start,
  output logic             dir,
  output logic [IDX_W-1:0] seq_idx_control,
  output logic [IDX_W-1:0] x_addr,
  output logic             h_wr_en,
  output logic [IDX_W-1:0] h_wr_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ADVANCE, FINISH} state_t;

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(SEQ_LEN - 1);
  localparam logic [TO_W-1:0]  WD_TC  = TO_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] k;
  logic             dir_q;
  logic [TO_W-1:0]  wd;
  logic             err_q;
  logic             last_run;
  logic             wd_tc;

  // Both run orders end on the backward run with k at its last value.
  assign last_run = dir_q && (k == LAST_K);
  assign wd_tc    = (wd == WD_TC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (cell_done)  state_nxt = ADVANCE;
        else if (wd_tc) state_nxt = FINISH;
      end
      ADVANCE:   state_nxt = last_run ? FINISH : ISSUE;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k     <= '0;
      dir_q <= 1'b0;
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k     <= '0;
            dir_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        ISSUE: wd <= '0;
        WAIT_DONE: begin
          if (!cell_done) begin
            if (wd_tc) err_q <= 1'b1;
            else       wd    <= wd + 1'b1;
          end
        end
        ADVANCE: begin
          // Indices only move on leaving ADVANCE so h_wr_addr still names the finished run.
          if (!last_run) begin
            if (INTERLEAVE != 0) begin
              if (dir_q) begin
                dir_q <= 1'b0;
                k     <= k + 1'b1;
              end else begin
                dir_q <= 1'b1;
              end
            end else begin
              if (k == LAST_K) begin
                dir_q <= 1'b1;
                k     <= '0;
              end else begin
                k     <= k + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cell_start      = (state == ISSUE);
    h_wr_en         = (state == ADVANCE);
    done            = (state == FINISH);
    busy            = (state != IDLE);
    err             = err_q;
    dir             = dir_q;
    seq_idx_control = k;
    x_addr          = dir_q ? (LAST_K - k) : k;
    h_wr_addr       = x_addr;
  end

endmodule
